// File: rtl/rmw_queue_if.sv
// Bus bundle for the RMW queue. It carries the schedule handshake, the load
// return, the flag port, the LSU write-back and the AGU address check.
interface rmw_queue_if #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 16
);
  logic              sched_valid;
  logic              sched_ready;
  logic [2:0]        sched_fn;
  logic [ADDR_W-1:0] sched_addr;
  logic [DATA_W-1:0] sched_operand;
  logic              sched_wr_flags;
  logic              sched_carry_mask;
  logic [ADDR_W-1:0] agu_addr;
  logic              mem_rdy;
  logic [DATA_W-1:0] mem_data_in;
  logic [15:0]       rf_flags_in;
  logic              rf_flags_wr;
  logic [15:0]       rf_flags_out;
  logic              lsu_data_rdy;
  logic [ADDR_W-1:0] lsu_addr;
  logic [DATA_W-1:0] lsu_data;
  logic              lsu_ack;
  logic              lsu_deny_op;

  // Side that drives requests, load data, flags and acks.
  modport master (
    output sched_valid, sched_fn, sched_addr, sched_operand, sched_wr_flags,
           sched_carry_mask, agu_addr, mem_rdy, mem_data_in, rf_flags_in, lsu_ack,
    input  sched_ready, rf_flags_wr, rf_flags_out, lsu_data_rdy, lsu_addr,
           lsu_data, lsu_deny_op
  );

  // The RMW queue itself.
  modport slave (
    input  sched_valid, sched_fn, sched_addr, sched_operand, sched_wr_flags,
           sched_carry_mask, agu_addr, mem_rdy, mem_data_in, rf_flags_in, lsu_ack,
    output sched_ready, rf_flags_wr, rf_flags_out, lsu_data_rdy, lsu_addr,
           lsu_data, lsu_deny_op
  );
endinterface

// File: rtl/rmw_queue.sv
// In-order read-modify-write queue. Ops are pushed by the scheduler. Load data
// is matched to the oldest unloaded entry, and the head result (data and flags)
// is computed combinationally and handed to the LSU. AGU accesses to any
// in-flight address are denied.
module rmw_queue #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 16,
  parameter int DEPTH  = 2
) (
  input  logic         clk,
  input  logic         a_rst,
  rmw_queue_if.slave   bus
);
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);

  typedef enum logic [2:0] {
    FN_INC = 3'b000, FN_DEC = 3'b001, FN_DEP = 3'b010, FN_LSR = 3'b011,
    FN_ASL = 3'b100, FN_TSB = 3'b101, FN_TRB = 3'b110, FN_XCH = 3'b111
  } fn_e;

  typedef struct packed {
    logic              valid;
    logic              loaded;
    fn_e               fn;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] operand;
    logic [DATA_W-1:0] data;
    logic              wr_flags;
    logic              carry_mask;
  } entry_t;

  entry_t            ent_q [DEPTH];
  entry_t            ent_d [DEPTH];
  logic [PTR_W-1:0]  head_q, head_d;
  logic [PTR_W-1:0]  ld_q, ld_d;
  logic [PTR_W-1:0]  tail_q, tail_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;

  entry_t            head;
  logic              push, pop, ld_hit;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    if (p == PTR_W'(DEPTH - 1)) return '0;
    return p + PTR_W'(1);
  endfunction

  assign head             = ent_q[head_q];
  assign bus.sched_ready  = (cnt_q != CNT_W'(DEPTH));
  assign bus.lsu_data_rdy = head.valid & head.loaded;
  assign push             = bus.sched_valid & bus.sched_ready;
  assign pop              = bus.lsu_data_rdy & bus.lsu_ack;
  // The load pointer sits on the tail once everything is loaded. That entry is
  // invalid, so a stray mem_rdy, or one on the entry's own push edge, is dropped.
  assign ld_hit           = bus.mem_rdy & ent_q[ld_q].valid & ~ent_q[ld_q].loaded;

  // Next-state for entries, pointers and occupancy.
  always_comb begin
    ent_d  = ent_q;
    head_d = head_q;
    ld_d   = ld_q;
    tail_d = tail_q;
    cnt_d  = cnt_q;
    if (pop) begin
      ent_d[head_q].valid  = 1'b0;
      ent_d[head_q].loaded = 1'b0;
      head_d               = ptr_inc(head_q);
    end
    if (ld_hit) begin
      ent_d[ld_q].loaded = 1'b1;
      ent_d[ld_q].data   = bus.mem_data_in;
      ld_d               = ptr_inc(ld_q);
    end
    if (push) begin
      ent_d[tail_q].valid      = 1'b1;
      ent_d[tail_q].loaded     = 1'b0;
      ent_d[tail_q].fn         = fn_e'(bus.sched_fn);
      ent_d[tail_q].addr       = bus.sched_addr;
      ent_d[tail_q].operand    = bus.sched_operand;
      ent_d[tail_q].wr_flags   = bus.sched_wr_flags;
      ent_d[tail_q].carry_mask = bus.sched_carry_mask;
      tail_d                   = ptr_inc(tail_q);
    end
    case ({push, pop})
      2'b10:   cnt_d = cnt_q + CNT_W'(1);
      2'b01:   cnt_d = cnt_q - CNT_W'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  // Queue state registers. Reset drops every entry immediately.
  always_ff @(posedge clk or posedge a_rst) begin
    if (a_rst) begin
      for (int i = 0; i < DEPTH; i++) ent_q[i] <= '0;
      head_q <= '0;
      ld_q   <= '0;
      tail_q <= '0;
      cnt_q  <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) ent_q[i] <= ent_d[i];
      head_q <= head_d;
      ld_q   <= ld_d;
      tail_q <= tail_d;
      cnt_q  <= cnt_d;
    end
  end

  // Modify stage: result word and C/Z/A for the head entry. Flags are taken
  // live, so the values applied are those present in the pop cycle.
  logic [DATA_W-1:0] res;
  logic              cin, c_flag, z_flag, a_flag;

  // Per-function ALU for the head entry.
  always_comb begin
    cin    = bus.rf_flags_in[0] & head.carry_mask;
    res    = head.data;
    c_flag = bus.rf_flags_in[0];
    a_flag = 1'b0;
    z_flag = 1'b0;
    case (head.fn)
      FN_INC: res = head.data + DATA_W'(1);
      FN_DEC: res = head.data - DATA_W'(1);
      FN_DEP: begin
        a_flag = |head.data;
        res    = head.data - DATA_W'(a_flag);
      end
      FN_LSR: begin
        res    = {cin, head.data[DATA_W-1:1]};
        c_flag = head.data[0];
      end
      FN_ASL: begin
        res    = {head.data[DATA_W-2:0], cin};
        c_flag = head.data[DATA_W-1];
      end
      FN_TSB: res = head.data | head.operand;
      FN_TRB: res = head.data & ~head.operand;
      FN_XCH: res = head.operand;
      default: res = head.data;
    endcase
    case (head.fn)
      FN_TSB, FN_TRB: z_flag = ((head.data & head.operand) == '0);
      FN_XCH:         z_flag = (head.data == '0);
      default:        z_flag = (res == '0);
    endcase
  end

  assign bus.lsu_addr     = head.addr;
  assign bus.lsu_data     = res;
  assign bus.rf_flags_out = {bus.rf_flags_in[15:5], a_flag, bus.rf_flags_in[3:2], z_flag, c_flag};
  assign bus.rf_flags_wr  = pop & head.wr_flags;

  // Address hazard check against every live entry, including the head as it pops.
  always_comb begin
    bus.lsu_deny_op = 1'b0;
    for (int i = 0; i < DEPTH; i++)
      if (ent_q[i].valid && ent_q[i].addr == bus.agu_addr) bus.lsu_deny_op = 1'b1;
  end
endmodule

// File: tb/tb_rmw_queue.sv
// Scoreboard bench for rmw_queue. The stimulus pushes hand-computed results;
// a forked monitor pops and compares on every LSU write-back.
module tb_rmw_queue;
  logic clk = 1'b0;
  logic a_rst;
  always #5 clk = ~clk;

  rmw_queue_if #(.DATA_W(16), .ADDR_W(16)) bus ();
  rmw_queue #(.DATA_W(16), .ADDR_W(16), .DEPTH(2)) dut (.clk(clk), .a_rst(a_rst), .bus(bus));

  typedef struct {
    logic [15:0] addr;
    logic [15:0] data;
    logic [15:0] flags;
    logic        wr;
  } exp_t;

  exp_t sb[$];
  int n_checks = 0;
  int n_pass   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h", name, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic monitor();
    exp_t e;
    forever begin
      @(negedge clk);
      if (!a_rst && bus.lsu_data_rdy && bus.lsu_ack) begin
        if (sb.size() == 0) begin
          n_checks++;
          $display("FAIL pop_unexpected: got write at %h, expected none", bus.lsu_addr);
        end else begin
          e = sb.pop_front();
          chk("lsu_addr", 32'(bus.lsu_addr), 32'(e.addr));
          chk("lsu_data", 32'(bus.lsu_data), 32'(e.data));
          chk("rf_flags_out", 32'(bus.rf_flags_out), 32'(e.flags));
          chk("rf_flags_wr", 32'(bus.rf_flags_wr), 32'(e.wr));
        end
      end
    end
  endtask

  task automatic set_op(input logic [2:0] fn, input logic [15:0] addr, input logic [15:0] opnd,
                        input logic wr, input logic cm);
    bus.sched_fn         = fn;
    bus.sched_addr       = addr;
    bus.sched_operand    = opnd;
    bus.sched_wr_flags   = wr;
    bus.sched_carry_mask = cm;
  endtask

  // Single op: push, load, ack with the flags held throughout.
  task automatic run_op(input logic [2:0] fn, input logic [15:0] addr, input logic [15:0] opnd,
                        input logic wr, input logic cm, input logic [15:0] flags,
                        input logic [15:0] ld, input logic [15:0] exp_d, input logic [15:0] exp_f);
    bus.rf_flags_in = flags;
    set_op(fn, addr, opnd, wr, cm);
    bus.sched_valid = 1'b1;
    sb.push_back('{addr, exp_d, exp_f, wr});
    tick();
    bus.sched_valid = 1'b0;
    bus.mem_rdy     = 1'b1;
    bus.mem_data_in = ld;
    tick();
    bus.mem_rdy = 1'b0;
    bus.lsu_ack = 1'b1;
    tick();
    bus.lsu_ack = 1'b0;
  endtask

  initial begin
    fork
      monitor();
      begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "timeout");
      end
    join_none

    a_rst = 1'b1;
    bus.sched_valid = 1'b0;
    set_op(3'd0, 16'h0, 16'h0, 1'b0, 1'b0);
    bus.agu_addr    = 16'h0000;
    bus.mem_rdy     = 1'b0;
    bus.mem_data_in = 16'h0;
    bus.rf_flags_in = 16'hFFFF;
    bus.lsu_ack     = 1'b0;

    // Reset state.
    @(negedge clk);
    chk("rst_sched_ready", 32'(bus.sched_ready), 32'd1);
    chk("rst_lsu_data_rdy", 32'(bus.lsu_data_rdy), 32'd0);
    chk("rst_rf_flags_wr", 32'(bus.rf_flags_wr), 32'd0);
    chk("rst_lsu_deny_op", 32'(bus.lsu_deny_op), 32'd0);
    chk("rst_lsu_addr", 32'(bus.lsu_addr), 32'h0000);
    chk("rst_lsu_data", 32'(bus.lsu_data), 32'h0001);
    chk("rst_rf_flags_out", 32'(bus.rf_flags_out), 32'hFFED);
    tick();
    a_rst = 1'b0;
    bus.rf_flags_in = 16'h0000;
    tick();

    // Single ops:  fn    addr      operand   wr cm flags     load      result    flags_out
    run_op(3'd0, 16'h00FF, 16'h0000, 1, 0, 16'h0000, 16'h00FF, 16'h0100, 16'h0000);
    run_op(3'd2, 16'h0010, 16'h0000, 0, 0, 16'h0000, 16'h0000, 16'h0000, 16'h0002);
    run_op(3'd2, 16'h0011, 16'h0000, 1, 0, 16'h0000, 16'h0001, 16'h0000, 16'h0012);
    run_op(3'd3, 16'h0012, 16'h0000, 1, 1, 16'h0001, 16'h0001, 16'h8000, 16'h0001);
    run_op(3'd3, 16'h0013, 16'h0000, 0, 0, 16'h0001, 16'h0002, 16'h0001, 16'h0000);
    run_op(3'd4, 16'h0014, 16'h0000, 1, 0, 16'h0001, 16'h8000, 16'h0000, 16'h0003);
    run_op(3'd5, 16'h0015, 16'h0F00, 1, 0, 16'hFFFF, 16'h0100, 16'h0F00, 16'hFFED);
    run_op(3'd6, 16'h0016, 16'h0F00, 0, 0, 16'hFFFF, 16'h0100, 16'h0000, 16'hFFED);
    run_op(3'd7, 16'h0017, 16'h1234, 1, 0, 16'h0000, 16'h0000, 16'h1234, 16'h0002);
    run_op(3'd1, 16'h0018, 16'h0000, 0, 0, 16'h0001, 16'h0000, 16'hFFFF, 16'h0001);
    run_op(3'd0, 16'h0019, 16'h0000, 1, 0, 16'h0010, 16'hFFFF, 16'h0000, 16'h0002);
    bus.rf_flags_in = 16'h0000;

    // Full queue: A and B back-to-back, C held until the ack cycle plus one.
    set_op(3'd0, 16'h0100, 16'h0000, 1'b1, 1'b0);
    bus.sched_valid = 1'b1;
    sb.push_back('{16'h0100, 16'h0011, 16'h0000, 1'b1});
    tick();
    set_op(3'd1, 16'h0200, 16'h0000, 1'b0, 1'b0);
    sb.push_back('{16'h0200, 16'h001F, 16'h0000, 1'b0});
    tick();
    set_op(3'd7, 16'h0300, 16'h1234, 1'b1, 1'b0);
    sb.push_back('{16'h0300, 16'h1234, 16'h0000, 1'b1});
    bus.agu_addr    = 16'h0200;
    bus.mem_rdy     = 1'b1;
    bus.mem_data_in = 16'h0010;
    @(negedge clk);
    chk("full_sched_ready", 32'(bus.sched_ready), 32'd0);
    chk("deny_queued", 32'(bus.lsu_deny_op), 32'd1);
    tick();
    bus.mem_data_in = 16'h0020;
    @(negedge clk);
    chk("full_sched_ready2", 32'(bus.sched_ready), 32'd0);
    tick();
    bus.mem_rdy  = 1'b0;
    bus.lsu_ack  = 1'b1;
    bus.agu_addr = 16'h0100;
    @(negedge clk);
    chk("full_ready_ack_cycle", 32'(bus.sched_ready), 32'd0);
    chk("deny_head_popping", 32'(bus.lsu_deny_op), 32'd1);
    tick();
    @(negedge clk);
    chk("ready_after_ack", 32'(bus.sched_ready), 32'd1);
    tick();
    bus.sched_valid = 1'b0;
    bus.lsu_ack     = 1'b0;
    bus.agu_addr    = 16'h0200;
    #1;
    chk("deny_after_pop", 32'(bus.lsu_deny_op), 32'd0);
    chk("c_not_loaded", 32'(bus.lsu_data_rdy), 32'd0);
    bus.agu_addr = 16'h0300;
    #1;
    chk("deny_c_queued", 32'(bus.lsu_deny_op), 32'd1);
    bus.mem_rdy     = 1'b1;
    bus.mem_data_in = 16'h5555;
    tick();
    bus.mem_rdy = 1'b0;
    bus.lsu_ack = 1'b1;
    tick();
    bus.lsu_ack = 1'b0;
    @(negedge clk);
    chk("deny_after_final_ack", 32'(bus.lsu_deny_op), 32'd0);

    // Load data on the push edge is not captured by the new entry.
    tick();
    set_op(3'd0, 16'h0400, 16'h0000, 1'b0, 1'b0);
    bus.sched_valid = 1'b1;
    bus.mem_rdy     = 1'b1;
    bus.mem_data_in = 16'hDEAD;
    sb.push_back('{16'h0400, 16'h0008, 16'h0000, 1'b0});
    tick();
    bus.sched_valid = 1'b0;
    bus.mem_data_in = 16'h0007;
    @(negedge clk);
    chk("no_load_on_push", 32'(bus.lsu_data_rdy), 32'd0);
    tick();
    bus.mem_rdy = 1'b0;
    bus.lsu_ack = 1'b1;
    tick();
    bus.lsu_ack = 1'b0;

    // Reset mid-queue discards everything at once.
    set_op(3'd0, 16'h0500, 16'h0000, 1'b1, 1'b0);
    bus.sched_valid = 1'b1;
    tick();
    set_op(3'd0, 16'h0600, 16'h0000, 1'b1, 1'b0);
    bus.mem_rdy     = 1'b1;
    bus.mem_data_in = 16'h0001;
    tick();
    bus.sched_valid = 1'b0;
    bus.mem_rdy     = 1'b0;
    bus.agu_addr    = 16'h0500;
    #1;
    chk("pre_rst_data_rdy", 32'(bus.lsu_data_rdy), 32'd1);
    a_rst = 1'b1;
    #1;
    chk("mid_rst_data_rdy", 32'(bus.lsu_data_rdy), 32'd0);
    chk("mid_rst_sched_ready", 32'(bus.sched_ready), 32'd1);
    chk("mid_rst_deny", 32'(bus.lsu_deny_op), 32'd0);
    chk("mid_rst_lsu_data", 32'(bus.lsu_data), 32'h0001);
    tick();
    a_rst = 1'b0;
    tick();
    run_op(3'd0, 16'h0700, 16'h0000, 1, 0, 16'h0000, 16'h0041, 16'h0042, 16'h0000);

    tick();
    chk("scoreboard_empty", 32'(sb.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule

// File: doc/rmw_queue.md
# rmw_queue

Parametrised read-modify-write unit sitting between the scheduler, the AGU and the LSU of the 65HE06 core. It accepts up to DEPTH outstanding RMW operations and matches returning load data to them in order. It computes the modified word and flags for the oldest entry, hands the result to the LSU for write-back, and blocks AGU accesses to any address still in flight. It extends the single-slot RMW ALU with:
- configurable width and queue depth;
- a full valid/ready schedule handshake;
- bit set/reset and exchange functions.

## Interface
Parameters:
- DATA_W, 16, data word width (≥2)
- ADDR_W, 16, address width
- DEPTH, 2, outstanding RMW entries (power of two, ≥1)

Ports:
- clk  in  1  clock
- a_rst  in  1  reset, asynchronous, active-high
- sched_valid  in  1  new RMW op offered
- sched_ready  out  1  queue can accept (count != DEPTH)
- sched_fn  in  3  function code
- sched_addr  in  ADDR_W  target address
- sched_operand  in  DATA_W  mask/value for TSB/TRB/XCH
- sched_wr_flags  in  1  op writes flags
- sched_carry_mask  in  1  use carry as shift-in
- agu_addr  in  ADDR_W  address the AGU is issuing
- mem_rdy  in  1  load data valid
- mem_data_in  in  DATA_W  load data
- rf_flags_in  in  16  current flags
- rf_flags_wr  out  1  write flags this cycle
- rf_flags_out  out  16  result flags
- lsu_data_rdy  out  1  head result valid
- lsu_addr  out  ADDR_W  head address
- lsu_data  out  DATA_W  head result
- lsu_ack  in  1  LSU takes head write
- lsu_deny_op  out  1  agu_addr hits an in-flight entry

## Operation
- Circular queue of DEPTH entries. Each entry holds: valid, loaded, fn, addr, operand, data, wr_flags, carry_mask.
- There are three pointers: head (oldest), load (oldest valid entry not yet loaded) and tail.
- Push occurs when sched_valid & sched_ready. The entry is written at tail with loaded=0.
- When mem_rdy is high and an entry is valid and not yet loaded, mem_data_in is written to that entry (the load pointer), its loaded bit is set, and the load pointer advances. When mem_rdy is high and no such entry exists, mem_rdy is ignored.
- lsu_data_rdy = head.valid & head.loaded.
- Pop occurs when lsu_data_rdy & lsu_ack. lsu_ack while lsu_data_rdy=0 is ignored.
- Result is combinational from the head entry. cin = rf_flags_in[0] & carry_mask.
  - 000 INC: data+1 (mod 2^DATA_W); C kept
  - 001 DEC: data−1 (mod 2^DATA_W); C kept
  - 010 DEP: data − (data!=0); A = (data!=0); C kept
  - 011 LSR/ROR: {result,C} = {cin,data}
  - 100 ASL/ROL: {C,result} = {data,cin}
  - 101 TSB: data | operand; Z = (data & operand)==0; C kept
  - 110 TRB: data & ~operand; Z = (data & operand)==0; C kept
  - 111 XCH: result = operand; Z = (data==0); C kept
- For codes 000–100, Z = (result==0). A = 0 for every code except DEP.
- rf_flags_out = {rf_flags_in[15:5], A, rf_flags_in[3:2], Z, C}.
- rf_flags_wr = lsu_data_rdy & lsu_ack & head.wr_flags.
- lsu_deny_op = 1 when any valid entry has addr == agu_addr. The check is combinational and includes the head in its pop cycle.

## Timing
- Reset: all entries are invalid and cleared to 0 (fn=INC), and count=0.
  - sched_ready=1, lsu_data_rdy=0, rf_flags_wr=0, lsu_deny_op=0, lsu_addr=0, lsu_data=1.
  - rf_flags_out = rf_flags_in with Z=0, A=0, C unchanged.
- a_rst asserted mid-operation discards all entries immediately; no partial write is issued.
- Minimum latency: push at edge T, mem_rdy sampled at edge T+1, lsu_data_rdy high in the cycle after T+1. An entry cannot capture load data on its own push edge.
- Push and pop in the same cycle are legal; count is unchanged.
- Push when full is impossible because sched_ready=0; there is no same-cycle bypass on pop.
- mem_rdy and pop on the same entry in the same cycle cannot occur, since the head must already be loaded to pop.
- Pointers wrap modulo DEPTH.
- Flags are read at the pop cycle. An op therefore sees flags written by the preceding pop only if it pops at least 1 cycle later.

## Test plan
- Reset, then push INC at 0x00FF with data 0x00FF → lsu_data=0x0100, Z=0, rf_flags_wr=wr_flags on ack.
- DEP on 0x0000 → lsu_data=0x0000, A=0, Z=1. DEP on 0x0001 → lsu_data=0x0000, A=1, Z=1.
- ROR with carry_mask=1, C=1, data 0x0001 → lsu_data=0x8000, C=1. ASL with carry_mask=0, data 0x8000 → lsu_data=0x0000, C=1, Z=1.
- DEPTH=2: push two ops back-to-back → sched_ready=0. A third sched_valid is held until the ack cycle plus 1. Load data is assigned in order, and lsu_addr follows push order.
- agu_addr equal to a queued (not yet acked) address → lsu_deny_op=1. After the final ack → 0.
- TSB with operand 0x0F00 on data 0x0100 → lsu_data=0x0F00, Z=0. TRB with the same inputs → lsu_data=0x0000, Z=0. Assert a_rst mid-queue → lsu_data_rdy=0 and sched_ready=1 immediately.
